uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the stage directly downstream of uart_tx.
- Consumes a serial 8N1 line (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit, no parity) and presents each received byte as a parallel word with a one-cycle valid strobe.
- Used as the loopback checker for uart_tx and as the host-facing receive path.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must equal the uart_tx setting; legal range >= 4.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- uart_rxd  input  1  serial line, asynchronous to clk.
- uart_rx_output  output  8  last correctly framed byte; held until the next good frame.
- uart_rx_valid  output  1  one-cycle pulse; uart_rx_output updated in the same cycle.
- uart_rx_frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- uart_rx_busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values (reset low, immediate): uart_rx_output=8'h00, uart_rx_valid=0, uart_rx_frame_error=0, uart_rx_busy=0, FSM=IDLE, bit counter=0, cycle counter=0, synchroniser flops=1.
- Input sync: 2-flop synchroniser on uart_rxd gives rxd_s. All decisions use rxd_s, which adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - When rxd_s==0 (cycle T0), go to START and clear the cycle counter.
  - Any other value stays in IDLE.
- START:
  - Counts to CLKS_PER_BIT/2-1 (integer division), then samples rxd_s at mid start bit.
  - Sample 0: clear the counter and go to DATA.
  - Sample 1: glitch; return to IDLE with no pulse.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rxd_s and shift it in LSB-first, i.e. into the MSB of the shift register, shifting right.
  - After the 8th sample, go to STOP.
  - Data bit k is sampled at T0 + CLKS_PER_BIT/2-1 + (k+1)*CLKS_PER_BIT.
- STOP:
  - Samples once at T0 + CLKS_PER_BIT/2-1 + 9*CLKS_PER_BIT.
  - Sample 1: on the next edge, uart_rx_output <= shift register, uart_rx_valid=1 for exactly one cycle, FSM to IDLE.
  - Sample 0: uart_rx_frame_error=1 for one cycle, uart_rx_output unchanged, FSM to WAIT_HIGH.
- WAIT_HIGH (break/framing recovery): stays until rxd_s==1, then goes to IDLE. This prevents a held-low line from being decoded as 8'h00 frames.
- Back-to-back frames:
  - Returning to IDLE at mid stop bit lets the next start edge be caught with zero gap.
  - Receiver tolerates up to roughly +/-4% baud mismatch for CLKS_PER_BIT >= 16.
- uart_rx_valid and uart_rx_frame_error are never high in the same cycle.
- Reset mid-frame: immediate abort. After reset deassertion the block waits in IDLE for a falling edge. A partial frame in progress is picked up at its next 1→0 transition; no valid pulse may be produced from the aborted frame's stale shift contents.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT); it wraps to 0 on each sample.
  - Bit counter is 3 bits and terminates at 7.

Decomposition:
- Package uart_pkg:
  - FSM state enum (uart_rx_state_t).
  - Constant UART_DATA_BITS=8.
  - Shared CLKS_PER_BIT default, so tx and rx cannot diverge.
- Sub-module uart_sync2: generic 2-flop synchroniser with parameterised reset value (1 here); reusable for other async inputs.

Test Plan:
- Reset held 100 cycles, then send 8'h34 from uart_tx (CLKS_PER_BIT=16) → exactly one uart_rx_valid pulse, uart_rx_output=8'h34, valid at T0+2+7+144+1 cycles relative to the line falling edge; no frame_error.
- Two back-to-back frames 8'h55 then 8'hA3 with zero idle gap → two valid pulses 160 cycles apart, outputs 8'h55 then 8'hA3.
- Low glitch of 3 cycles on an idle line → FSM returns to IDLE, no valid, no frame_error, busy high for at most 8 cycles.
- Frame 8'hF0 with stop bit forced low, then line held low 40 bit-times, then released → exactly one frame_error pulse, uart_rx_output keeps the previous value 8'hA3, no valid while low; the next good frame 8'h01 is received correctly.
- Reset asserted mid-DATA of frame 8'hFF, released 5 cycles later → no valid from the aborted frame, outputs at reset values, busy=0; the next frame 8'h7E is received correctly.
- Loopback of all 256 byte values through uart_tx → uart_rx → 256 valid pulses, each output equal to its input, zero frame errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the receiver FSM state type, the frame data width and the default
// bit period, so that uart_tx and uart_rx cannot drift apart.
package uart_pkg;

    // Default clk cycles per serial bit, common to tx and rx
    localparam int unsigned UART_CLKS_PER_BIT = 16;

    // Data bits per 8N1 frame
    localparam int unsigned UART_DATA_BITS = 8;

    // Receiver FSM states
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles behind d
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; meta is never used outside this module
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART 8N1 receiver.
// Samples the serial line at mid-bit, assembles LSB-first data and presents
// each correctly framed byte with a one-cycle valid strobe. A low stop bit
// raises a one-cycle frame error and the receiver then waits for the line to
// return high before looking for a new start bit.
// Ports:
//   clk                 - system clock
//   reset               - asynchronous active-low reset
//   uart_rxd            - serial input, asynchronous to clk
//   uart_rx_output      - last good byte, held until the next good frame
//   uart_rx_valid       - one-cycle pulse when uart_rx_output updates
//   uart_rx_frame_error - one-cycle pulse when the stop bit is sampled low
//   uart_rx_busy        - high whenever the FSM is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] uart_rx_output,
    output logic                 uart_rx_valid,
    output logic                 uart_rx_frame_error,
    output logic                 uart_rx_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = 3;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    logic rxd_s;

    uart_rx_state_t       state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
    logic                 busy_nxt;

    // Bring the serial line into the clk domain; idles high
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= RX_IDLE;
            cnt                 <= '0;
            bit_cnt             <= '0;
            shift               <= '0;
            uart_rx_output      <= '0;
            uart_rx_valid       <= 1'b0;
            uart_rx_frame_error <= 1'b0;
            uart_rx_busy        <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            bit_cnt             <= bit_cnt_nxt;
            shift               <= shift_nxt;
            uart_rx_output      <= data_nxt;
            uart_rx_valid       <= valid_nxt;
            uart_rx_frame_error <= ferr_nxt;
            uart_rx_busy        <= busy_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        data_nxt    = uart_rx_output;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            RX_IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                // The detection cycle itself is count 0 of the half bit
                if (!rxd_s) begin
                    state_nxt = RX_START;
                    cnt_nxt   = CNT_ONE;
                end
            end

            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    // High at mid start bit is a glitch, not a frame
                    state_nxt = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rxd_s, shift[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = RX_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_nxt = '0;
                    // Leaving at mid stop bit lets a zero-gap start edge be seen
                    if (rxd_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            RX_WAIT_HIGH: begin
                // A held-low (break) line must not decode as 8'h00 frames
                cnt_nxt = '0;
                if (rxd_s) begin
                    state_nxt = RX_IDLE;
                end
            end

            default: begin
                state_nxt = RX_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != RX_IDLE);
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial-line driver queues the expected
// response of each frame, and a monitor compares every valid or frame-error
// pulse against the queue head (kind, byte, arrival cycle).
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    // Line fall to output pulse: 2 sync + 7 half bit + 9 bits + 1 register
    localparam int LAT = 2 + 7 + 9 * 16 + 1;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       uart_rxd;
    logic [7:0] uart_rx_output;
    logic       uart_rx_valid;
    logic       uart_rx_frame_error;
    logic       uart_rx_busy;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] last_good;
    int         cyc;
    int         checks;
    int         errors;
    int         overlap;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .uart_rxd            (uart_rxd),
        .uart_rx_output      (uart_rx_output),
        .uart_rx_valid       (uart_rx_valid),
        .uart_rx_frame_error (uart_rx_frame_error),
        .uart_rx_busy        (uart_rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n clk edges and settle 1 time unit after the last one
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame and queue the response it should produce
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        exp_t e;
        uart_rxd = 1'b0;
        e.is_err = ~stop_bit;
        e.data   = stop_bit ? d : last_good;
        e.cyc    = cyc + LAT;
        if (stop_bit) last_good = d;
        exp_q.push_back(e);
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            hold(CPB);
        end
        uart_rxd = stop_bit;
        hold(CPB);
    endtask

    // Monitor: every output pulse must match the queue head
    always @(negedge clk) begin
        if (reset) begin
            if (uart_rx_valid && uart_rx_frame_error) overlap++;
            if (uart_rx_valid || uart_rx_frame_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {uart_rx_valid, uart_rx_frame_error}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_kind_ferr", int'(uart_rx_frame_error), int'(mon_e.is_err));
                    chk("pulse_data", int'(uart_rx_output), int'(mon_e.data));
                    chk("pulse_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        overlap   = 0;
        last_good = 8'h00;
        uart_rxd  = 1'b1;
        reset     = 1'b0;

        // Reset held 100 cycles
        hold(100);
        chk("reset_output", int'(uart_rx_output), 0);
        chk("reset_valid", int'(uart_rx_valid), 0);
        chk("reset_ferr", int'(uart_rx_frame_error), 0);
        chk("reset_busy", int'(uart_rx_busy), 0);
        reset = 1'b1;
        hold(CPB);
        chk("idle_busy", int'(uart_rx_busy), 0);

        // Single frame
        send_frame(8'h34, 1'b1);
        hold(2 * CPB);

        // Back-to-back, zero gap
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        hold(2 * CPB);

        // 3-cycle low glitch on an idle line
        uart_rxd = 1'b0;
        hold(3);
        uart_rxd = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (uart_rx_busy) busy_cnt++;
            hold(1);
        end
        chk("glitch_busy_seen", int'(busy_cnt > 0), 1);
        chk("glitch_busy_le8", int'(busy_cnt <= 8), 1);
        chk("glitch_back_idle", int'(uart_rx_busy), 0);
        chk("glitch_output_held", int'(uart_rx_output), 8'hA3);

        // Bad stop bit, then line held low 40 bit-times
        send_frame(8'hF0, 1'b0);
        hold(40 * CPB);
        chk("break_busy", int'(uart_rx_busy), 1);
        chk("break_output_held", int'(uart_rx_output), 8'hA3);
        uart_rxd = 1'b1;
        hold(2 * CPB);
        chk("break_released_idle", int'(uart_rx_busy), 0);
        send_frame(8'h01, 1'b1);
        hold(2 * CPB);

        // Reset mid-DATA of 8'hFF, released 5 cycles later
        uart_rxd = 1'b0;
        hold(CPB);
        uart_rxd = 1'b1;
        hold(3 * CPB + 5);
        reset = 1'b0;
        last_good = 8'h00;
        hold(1);
        chk("midreset_output", int'(uart_rx_output), 0);
        chk("midreset_valid", int'(uart_rx_valid), 0);
        chk("midreset_ferr", int'(uart_rx_frame_error), 0);
        chk("midreset_busy", int'(uart_rx_busy), 0);
        hold(4);
        reset = 1'b1;
        hold(6 * CPB);
        chk("after_reset_busy", int'(uart_rx_busy), 0);
        chk("after_reset_output", int'(uart_rx_output), 0);
        send_frame(8'h7E, 1'b1);
        hold(2 * CPB);

        // All 256 byte values back to back
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), 1'b1);
        end

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) hold(1);
        chk("queue_drained", exp_q.size(), 0);
        chk("valid_ferr_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx
